// File: rtl/nsr_vec_reader.sv
// Vector read sequencer for the neural state register file: walks the NSR read
// port one element per cycle and presents the packed vector over valid/ready.
module nsr_vec_reader #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int MAXE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [1:0]           req_vl,
   input  logic [AW-1:0]        req_base,
   output logic [AW-1:0]        nsr_ra,
   input  logic [DW-1:0]        nsr_rd,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW*MAXE-1:0]   out_data,
   output logic                 out_err
);

   localparam int CW = (MAXE > 1) ? $clog2(MAXE) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_READ = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]         r_state;
   logic [AW-1:0]      r_ra;
   logic [CW-1:0]      r_cnt;
   logic [CW-1:0]      r_last;
   logic [DW*MAXE-1:0] r_data;
   logic               r_err;

   logic [CW-1:0]      w_last;
   logic [AW-1:0]      w_ra_next;

   // Index of the final element for each legal VL code (1, 4, 16 elements).
   always_comb begin
      w_last = '0;
      case (req_vl)
         2'b00:   w_last = '0;
         2'b01:   w_last = CW'(3);
         default: w_last = CW'(MAXE - 1);
      endcase
   end

   // r_ra always equals base+cnt during READ, so the next address is a plain
   // increment with natural AW-bit wrap.
   assign w_ra_next = r_ra + AW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ra    <= '0;
         r_cnt   <= '0;
         r_last  <= '0;
         r_data  <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  r_cnt  <= '0;
                  r_data <= '0;
                  r_last <= w_last;
                  if (req_vl == 2'b11) begin
                     r_err   <= 1'b1;
                     r_state <= S_HOLD;
                  end else begin
                     r_err   <= 1'b0;
                     r_ra    <= req_base;
                     r_state <= S_READ;
                  end
               end
            end
            S_READ: begin
               r_data[DW*r_cnt +: DW] <= nsr_rd;
               if (r_cnt == r_last) begin
                  r_state <= S_HOLD;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
                  r_ra  <= w_ra_next;
               end
            end
            S_HOLD: begin
               if (out_ready) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign out_valid = (r_state == S_HOLD);
   assign nsr_ra    = r_ra;
   assign out_data  = r_data;
   assign out_err   = r_err;

endmodule

// File: doc/nsr_vec_reader.md
Name: nsr_vec_reader

Overview:
- Read-side sequencer for the neural state register file (NSR, 32 x 32-bit entries, one combinational read port).
- Accepts a vector read request (base index + VL code) and walks the NSR read port one element per cycle.
- Packs the elements into a wide 512-bit vector and hands it to the vector execute/writeback stage over a valid/ready handshake.
- Mirrors the NSR write path, which stores VL-sized vectors as consecutive entries.

Parameters:
- DW, 32, element width; equals the NSR entry width.
- AW, 5, NSR index width (32 entries).
- MAXE, 16, maximum elements per vector; out_data width is DW*MAXE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_vl  in  2  vector length code: 00=1, 01=4, 10=16, 11=illegal.
- req_base  in  AW  first NSR index.
- nsr_ra  out  AW  NSR read address.
- nsr_rd  in  DW  NSR read data; combinational from nsr_ra, same cycle.
- out_valid  out  1  result vector valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DW*MAXE  packed vector; element i at bits [DW*i +: DW].
- out_err  out  1  result is from an illegal VL request.

Behaviour:
- FSM states: IDLE, READ, HOLD. Reset state is IDLE.
- Reset values: req_ready=1, out_valid=0, out_err=0, out_data=0, nsr_ra=0, element counter=0.
- IDLE:
  - req_ready=1.
  - Request is accepted on a rising edge where req_valid=1.
  - On accept, latch base, set N from req_vl (1/4/16), clear the counter and clear out_data to 0.
  - If VL=11: go to HOLD with out_err=1 and out_data=0; no NSR reads.
  - Otherwise go to READ.
- READ:
  - req_ready=0.
  - nsr_ra = (base + cnt) mod 32, i.e. AW-bit wrap, so base 30 with VL=01 reads 30, 31, 0, 1.
  - Each cycle, capture nsr_rd into element slot cnt and increment cnt.
  - After capturing element N-1, go to HOLD.
- HOLD:
  - out_valid=1; req_ready=0.
  - out_data and out_err are stable while waiting.
  - On a rising edge with out_ready=1, go to IDLE and drop out_valid.
  - Backpressure may hold the block in HOLD indefinitely.
- nsr_ra in IDLE and HOLD holds its last value; no side effects.
- Latency from accept edge to out_valid=1:
  - N cycles for legal VL (1 / 4 / 16).
  - 1 cycle for illegal VL.
- Unused upper slots (index >= N) are always zero.
- No request is accepted in the same cycle a result is consumed. The next request can be accepted no earlier than the first cycle after the return to IDLE. Maximum throughput is therefore one vector per N+2 cycles.
- NSR writes during READ are not interlocked: each element reflects NSR contents at its own capture cycle. Hazard avoidance is the issuing stage's responsibility.
- rst asserted in any state, including mid-READ or HOLD: immediately return to reset values. The partially read vector is discarded and no out_valid is produced.
- req_valid while req_ready=0 is ignored; the requester must hold it until accepted.

Test Plan:
- NSR model with entry k = 0xA000_0000+k; req VL=00, base=7 -> out_valid 1 cycle after accept; out_data[31:0]=0xA000_0007; bits 511:32 = 0; out_err=0.
- VL=01, base=30 -> nsr_ra sequence 30, 31, 0, 1 on consecutive cycles; out_data[127:0] = {0xA000_0001, 0xA000_0000, 0xA000_001F, 0xA000_001E}; out_valid 4 cycles after accept.
- VL=10, base=0, out_ready held 0 for 5 cycles after out_valid -> out_data holds elements 0..15 stable and req_ready=0 throughout; consumed on the first out_ready=1 edge; req_ready=1 next cycle.
- VL=11, base=3 -> out_valid after 1 cycle; out_err=1; out_data=0; nsr_ra never changes from its prior value.
- Assert rst asynchronously (mid-clock) after 6 elements of a VL=10 read -> out_valid=0 and req_ready=1 immediately; a following VL=00 base=2 request returns 0xA000_0002 with no stale upper data.
- Back-to-back requests with out_ready tied 1 -> second request accepted exactly on the first IDLE cycle after the first vector is consumed; no overlap of nsr_ra sequences.
